ibex_dummy_instr_ctrl: RTL and testbench
========================================

Name: ibex_dummy_instr_ctrl

Overview:
Sequences the dummy-instruction insertion datapath inside the Ibex core. It obtains LFSR seeds from an external entropy source over a req/ack handshake and loads them via the generator's seed port. It gates the generator's enable while seeding, and schedules periodic or software-triggered reseeds. It also keeps a saturating count of inserted dummy instructions for CSR readback.

Parameters:
EntropyW, 32, width of entropy word and generator seed
IntervalW, 16, width of reseed interval and interval counter
TimeoutW, 8, width of entropy handshake timeout counter
CountW, 16, width of saturating inserted-dummy counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
ctrl_en_i  in  1  CSR enable for dummy insertion
ctrl_mask_i  in  3  CSR insertion-rate mask
reseed_interval_i  in  IntervalW  dummies between automatic reseeds; 0 disables periodic reseed
reseed_now_i  in  1  single-cycle software reseed request
timeout_i  in  TimeoutW  entropy wait limit in cycles; 0 means no timeout
entropy_req_o  out  1  entropy request
entropy_ack_i  in  1  entropy valid/ack, one cycle
entropy_data_i  in  EntropyW  entropy word, valid with ack
insert_dummy_instr_i  in  1  generator is inserting a dummy this cycle
id_in_ready_i  in  1  ID stage accepting
clear_count_i  in  1  clear dummy counter
dummy_instr_en_o  out  1  generator enable
dummy_instr_mask_o  out  3  generator mask
dummy_instr_seed_en_o  out  1  seed load strobe
dummy_instr_seed_o  out  EntropyW  seed value
dummy_count_o  out  CountW  saturating inserted-dummy count
busy_o  out  1  reseed in progress (REQ or SEED)
reseed_err_o  out  1  sticky: an entropy request timed out

Behaviour:
- Reset (rst_i=1 at posedge): state DISABLED. All outputs 0, all counters 0, reseed_pending 0, mask register 0.
- States: DISABLED, REQ, SEED, RUN.
- DISABLED: en_o=0. If ctrl_en_i=1, go to REQ next cycle. The first enable always seeds before insertion.
- REQ: entropy_req_o=1 and en_o=0.
  - Request is held until ack or timeout, even if ctrl_en_i drops.
  - On ack: capture entropy_data_i into seed register and clear reseed_pending. Go to SEED if ctrl_en_i=1, else DISABLED; no seed strobe in the DISABLED case.
  - Timeout counter counts REQ cycles. If timeout_i!=0 and count==timeout_i-1 with no ack: set reseed_err_o, drop req, keep the old seed. Go to RUN if ctrl_en_i=1, else DISABLED.
  - Ack and timeout in the same cycle: ack wins.
- SEED: exactly one cycle. seed_en_o=1, seed_o=seed register, en_o=0. Load mask register from ctrl_mask_i. Clear the interval counter. Go to RUN.
- RUN: en_o=1, mask_o=mask register.
  - Event = insert_dummy_instr_i & id_in_ready_i.
  - On an event: interval counter +1 and dummy counter +1.
  - Reseed trigger = reseed_pending, or (interval!=0 and an event occurs with interval counter==interval-1).
  - On trigger, go to REQ next cycle; en_o drops that next cycle.
  - ctrl_en_i=0 goes to DISABLED and has priority over the trigger.
- reseed_now_i: sets reseed_pending in any state except REQ. A pulse during REQ is absorbed by the current request. Pending is serviced on the next RUN cycle; it is cleared by ack, and also on entry to DISABLED.
- dummy_count_o: saturates at all-ones. clear_count_i clears it; if clear and an event occur together, result = 1.
- Interval change mid-run takes effect immediately. If the counter is already ≥ the new value, no reseed occurs until wrap; the counter wraps at 2^IntervalW.
- reseed_err_o clears only on reset.
- seed_o holds its value outside SEED.
- busy_o = (state==REQ) | (state==SEED).

Decomposition:
- Package ibex_dummy_ctrl_pkg holds:
  - state enum dummy_ctrl_state_e {DISABLED, REQ, SEED, RUN};
  - default widths EntropyW, IntervalW, TimeoutW, CountW;
  - mask width 3.
- One sub-module, ibex_dummy_sat_counter: parameterised width, with inc, clr and saturate-enable inputs. It is instanced for the dummy counter (saturating). The interval counter uses the same sub-module with saturation disabled (wrap).

Test Plan:
- Reset then ctrl_en_i=1, ack after 3 cycles with data 0xDEADBEEF → req high for 3 cycles; seed_en_o pulses once with seed_o=0xDEADBEEF; en_o=1 the cycle after; busy_o low after.
- RUN, interval=4, four events (insert&ready) → req rises the cycle after the 4th event; en_o=0 during REQ; dummy_count_o=4.
- timeout_i=5, no ack → req high exactly 5 cycles; reseed_err_o=1 and sticky; return to RUN with no seed_en pulse.
- ctrl_en_i dropped during REQ, ack 2 cycles later → req held until ack; no seed_en; state DISABLED; en_o stays 0.
- reseed_now_i pulse in RUN with interval=0 → REQ next cycle; pulse repeated during REQ → exactly one reseed.
- dummy_count_o at 0xFFFF plus an event → stays 0xFFFF; clear_count_i with a simultaneous event → 1.

Source files
------------

// File: rtl/ibex_dummy_ctrl_pkg.sv
// Shared types and default widths for the dummy-instruction control block.
package ibex_dummy_ctrl_pkg;

  localparam int unsigned EntropyW  = 32;
  localparam int unsigned IntervalW = 16;
  localparam int unsigned TimeoutW  = 8;
  localparam int unsigned CountW    = 16;
  localparam int unsigned MaskW     = 3;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    REQ      = 2'd1,
    SEED     = 2'd2,
    RUN      = 2'd3
  } dummy_ctrl_state_e;

endpackage

// File: rtl/ibex_dummy_sat_counter.sv
// Counter with synchronous clear and optional saturation at all-ones.
// clr and inc together load 1 so a same-cycle event is not lost.
module ibex_dummy_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  input  logic             sat_en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d;
  logic             at_max;

  assign at_max = (cnt_o == {Width{1'b1}});

  // Next count: clear has priority, saturation holds at all-ones when enabled.
  always_comb begin
    cnt_d = cnt_o;
    if (clr_i) begin
      cnt_d = inc_i ? Width'(1) : '0;
    end else if (inc_i && !(sat_en_i && at_max)) begin
      cnt_d = cnt_o + Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else begin
      cnt_o <= cnt_d;
    end
  end

endmodule

// File: rtl/ibex_dummy_instr_ctrl.sv
// Dummy-instruction sequencer: fetches LFSR seeds from entropy, loads them
// into the generator, gates generator enable while seeding, schedules
// periodic/software reseeds and counts inserted dummies.
module ibex_dummy_instr_ctrl
  import ibex_dummy_ctrl_pkg::*;
#(
  parameter int unsigned EntropyW  = ibex_dummy_ctrl_pkg::EntropyW,
  parameter int unsigned IntervalW = ibex_dummy_ctrl_pkg::IntervalW,
  parameter int unsigned TimeoutW  = ibex_dummy_ctrl_pkg::TimeoutW,
  parameter int unsigned CountW    = ibex_dummy_ctrl_pkg::CountW
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ctrl_en_i,
  input  logic [MaskW-1:0]     ctrl_mask_i,
  input  logic [IntervalW-1:0] reseed_interval_i,
  input  logic                 reseed_now_i,
  input  logic [TimeoutW-1:0]  timeout_i,
  output logic                 entropy_req_o,
  input  logic                 entropy_ack_i,
  input  logic [EntropyW-1:0]  entropy_data_i,
  input  logic                 insert_dummy_instr_i,
  input  logic                 id_in_ready_i,
  input  logic                 clear_count_i,
  output logic                 dummy_instr_en_o,
  output logic [MaskW-1:0]     dummy_instr_mask_o,
  output logic                 dummy_instr_seed_en_o,
  output logic [EntropyW-1:0]  dummy_instr_seed_o,
  output logic [CountW-1:0]    dummy_count_o,
  output logic                 busy_o,
  output logic                 reseed_err_o
);

  dummy_ctrl_state_e    state_q, state_d;
  logic [EntropyW-1:0]  seed_q, seed_d;
  logic [MaskW-1:0]     mask_q, mask_d;
  logic [TimeoutW-1:0]  tmo_q, tmo_d;
  logic                 pending_q, pending_d;
  logic                 err_set;
  logic                 interval_clr;
  logic                 run_event;
  logic                 interval_hit;
  logic                 timeout_hit;
  logic [IntervalW-1:0] interval_cnt;

  // Generator actually issued a dummy into ID while running.
  assign run_event = (state_q == RUN) & insert_dummy_instr_i & id_in_ready_i;

  // Periodic reseed fires on the event that completes the interval.
  assign interval_hit = (reseed_interval_i != '0) && run_event &&
                        (interval_cnt == reseed_interval_i - IntervalW'(1));

  // Entropy wait limit reached on this REQ cycle.
  assign timeout_hit = (timeout_i != '0) && (tmo_q == timeout_i - TimeoutW'(1));

  // Next-state, seed/mask capture, pending-reseed and timeout bookkeeping.
  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    mask_d       = mask_q;
    pending_d    = pending_q;
    tmo_d        = '0;
    err_set      = 1'b0;
    interval_clr = 1'b0;

    case (state_q)
      DISABLED: begin
        if (ctrl_en_i) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (entropy_ack_i) begin
          seed_d    = entropy_data_i;
          pending_d = 1'b0;
          state_d   = ctrl_en_i ? SEED : DISABLED;
        end else if (timeout_hit) begin
          err_set = 1'b1;
          state_d = ctrl_en_i ? RUN : DISABLED;
        end else begin
          tmo_d = tmo_q + TimeoutW'(1);
        end
      end
      SEED: begin
        mask_d       = ctrl_mask_i;
        interval_clr = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        if (!ctrl_en_i) begin
          state_d = DISABLED;
        end else if (pending_q || reseed_now_i || interval_hit) begin
          state_d = REQ;
        end
      end
      default: state_d = DISABLED;
    endcase

    // A request in flight absorbs software reseed pulses.
    if (reseed_now_i && (state_q != REQ)) begin
      pending_d = 1'b1;
    end
    // Disabling drops any outstanding reseed; the next enable seeds anyway.
    if ((state_d == DISABLED) && (state_q != DISABLED)) begin
      pending_d = 1'b0;
    end
  end

  // State, internal registers and outputs decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q               <= DISABLED;
      seed_q                <= '0;
      mask_q                <= '0;
      tmo_q                 <= '0;
      pending_q             <= 1'b0;
      entropy_req_o         <= 1'b0;
      dummy_instr_en_o      <= 1'b0;
      dummy_instr_mask_o    <= '0;
      dummy_instr_seed_en_o <= 1'b0;
      dummy_instr_seed_o    <= '0;
      busy_o                <= 1'b0;
      reseed_err_o          <= 1'b0;
    end else begin
      state_q               <= state_d;
      seed_q                <= seed_d;
      mask_q                <= mask_d;
      tmo_q                 <= tmo_d;
      pending_q             <= pending_d;
      entropy_req_o         <= (state_d == REQ);
      dummy_instr_en_o      <= (state_d == RUN);
      dummy_instr_mask_o    <= (state_d == RUN) ? mask_d : '0;
      dummy_instr_seed_en_o <= (state_d == SEED);
      busy_o                <= (state_d == REQ) || (state_d == SEED);
      if (state_d == SEED) begin
        dummy_instr_seed_o <= seed_d;
      end
      if (err_set) begin
        reseed_err_o <= 1'b1;
      end
    end
  end

  // Dummies since the last seed load; wraps so a shrunk interval waits for wrap.
  ibex_dummy_sat_counter #(
    .Width (IntervalW)
  ) u_interval_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (run_event),
    .clr_i    (interval_clr),
    .sat_en_i (1'b0),
    .cnt_o    (interval_cnt)
  );

  // CSR-visible inserted-dummy count, saturating.
  ibex_dummy_sat_counter #(
    .Width (CountW)
  ) u_dummy_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (run_event),
    .clr_i    (clear_count_i),
    .sat_en_i (1'b1),
    .cnt_o    (dummy_count_o)
  );

endmodule

// File: tb/tb_ibex_dummy_instr_ctrl.sv
// Bench for ibex_dummy_instr_ctrl: directed scenarios plus random traffic,
// all checked cycle by cycle against a behavioural model.
module tb_ibex_dummy_instr_ctrl;

  logic        clk;
  logic        rst;
  logic        ctrl_en;
  logic [2:0]  ctrl_mask;
  logic [15:0] interval;
  logic        reseed_now;
  logic [7:0]  timeout;
  logic        entropy_req;
  logic        entropy_ack;
  logic [31:0] entropy_data;
  logic        insert;
  logic        ready;
  logic        clear_count;
  logic        dummy_en;
  logic [2:0]  dummy_mask;
  logic        seed_en;
  logic [31:0] seed;
  logic [15:0] dummy_count;
  logic        busy;
  logic        reseed_err;

  ibex_dummy_instr_ctrl dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .ctrl_en_i             (ctrl_en),
    .ctrl_mask_i           (ctrl_mask),
    .reseed_interval_i     (interval),
    .reseed_now_i          (reseed_now),
    .timeout_i             (timeout),
    .entropy_req_o         (entropy_req),
    .entropy_ack_i         (entropy_ack),
    .entropy_data_i        (entropy_data),
    .insert_dummy_instr_i  (insert),
    .id_in_ready_i         (ready),
    .clear_count_i         (clear_count),
    .dummy_instr_en_o      (dummy_en),
    .dummy_instr_mask_o    (dummy_mask),
    .dummy_instr_seed_en_o (seed_en),
    .dummy_instr_seed_o    (seed),
    .dummy_count_o         (dummy_count),
    .busy_o                (busy),
    .reseed_err_o          (reseed_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode of operation plus the counters the rules mention.
  localparam int M_OFF  = 0;
  localparam int M_REQ  = 1;
  localparam int M_SEED = 2;
  localparam int M_RUN  = 3;

  int     m_mode;
  longint m_seed_cap;
  longint m_seed_out;
  int     m_mask;
  int     m_since_seed;
  int     m_wait;
  int     m_count;
  bit     m_pending;
  bit     m_err;

  task automatic model_step();
    int nxt;
    bit ev;
    bit hit;
    if (rst) begin
      m_mode = M_OFF; m_seed_cap = 0; m_seed_out = 0; m_mask = 0;
      m_since_seed = 0; m_wait = 0; m_count = 0; m_pending = 0; m_err = 0;
      return;
    end
    ev  = (m_mode == M_RUN) && insert && ready;
    hit = (int'(interval) != 0) && ev && (m_since_seed == int'(interval) - 1);
    nxt = m_mode;
    case (m_mode)
      M_OFF:  if (ctrl_en) nxt = M_REQ;
      M_REQ: begin
        if (entropy_ack) begin
          m_seed_cap = longint'(entropy_data);
          m_pending  = 0;
          nxt        = ctrl_en ? M_SEED : M_OFF;
        end else if (int'(timeout) != 0 && m_wait == int'(timeout) - 1) begin
          m_err = 1;
          nxt   = ctrl_en ? M_RUN : M_OFF;
        end
      end
      M_SEED: begin
        m_mask       = int'(ctrl_mask);
        m_since_seed = 0;
        nxt          = M_RUN;
      end
      M_RUN: begin
        if (!ctrl_en) nxt = M_OFF;
        else if (m_pending || reseed_now || hit) nxt = M_REQ;
      end
      default: nxt = M_OFF;
    endcase
    if (ev) m_since_seed = (m_since_seed + 1) % 65536;
    if (clear_count) m_count = ev ? 1 : 0;
    else if (ev && m_count < 65535) m_count++;
    m_wait = (m_mode == M_REQ && nxt == M_REQ) ? (m_wait + 1) % 256 : 0;
    if (reseed_now && m_mode != M_REQ) m_pending = 1;
    if (nxt == M_OFF && m_mode != M_OFF) m_pending = 0;
    if (nxt == M_SEED) m_seed_out = m_seed_cap;
    m_mode = nxt;
  endtask

  task automatic compare_all();
    check("req",     64'(entropy_req), 64'(m_mode == M_REQ));
    check("en",      64'(dummy_en),    64'(m_mode == M_RUN));
    check("mask",    64'(dummy_mask),  (m_mode == M_RUN) ? 64'(m_mask) : 64'(0));
    check("seed_en", 64'(seed_en),     64'(m_mode == M_SEED));
    check("seed",    64'(seed),        64'(m_seed_out));
    check("count",   64'(dummy_count), 64'(m_count));
    check("busy",    64'(busy),        64'(m_mode == M_REQ || m_mode == M_SEED));
    check("err",     64'(reseed_err),  64'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    bit seen_seed;

    rst = 1'b1; ctrl_en = 1'b0; ctrl_mask = 3'd0; interval = '0; reseed_now = 1'b0;
    timeout = '0; entropy_ack = 1'b0; entropy_data = '0; insert = 1'b0; ready = 1'b0;
    clear_count = 1'b0;
    step(); step();
    check("rst_req",   64'(entropy_req), 64'(0));
    check("rst_en",    64'(dummy_en),    64'(0));
    check("rst_count", 64'(dummy_count), 64'(0));
    check("rst_seed",  64'(seed),        64'(0));
    rst = 1'b0;

    // First enable: ack on the third request cycle.
    ctrl_en = 1'b1; ctrl_mask = 3'd5;
    step();
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (entropy_req) req_cycles++;
      entropy_ack  = (i == 2);
      entropy_data = 32'hDEADBEEF;
      step();
    end
    entropy_ack = 1'b0;
    check("t1_req_cycles", 64'(req_cycles), 64'(3));
    check("t1_seed_en",    64'(seed_en),    64'(1));
    check("t1_seed",       64'(seed),       64'(32'hDEADBEEF));
    check("t1_en_seed",    64'(dummy_en),   64'(0));
    step();
    check("t1_en_run",   64'(dummy_en),   64'(1));
    check("t1_busy_run", 64'(busy),       64'(0));
    check("t1_mask_run", 64'(dummy_mask), 64'(5));

    // Periodic reseed after four events.
    interval = 16'd4; insert = 1'b1; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_no_req_early", 64'(entropy_req), 64'(0));
    end
    step();
    insert = 1'b0;
    check("t2_req",   64'(entropy_req), 64'(1));
    check("t2_en",    64'(dummy_en),    64'(0));
    check("t2_count", 64'(dummy_count), 64'(4));
    entropy_ack = 1'b1; entropy_data = 32'h1234_5678;
    step();
    entropy_ack = 1'b0;
    step();

    // Entropy timeout: request for exactly five cycles, no seed load.
    interval = 16'd1; timeout = 8'd5; insert = 1'b1;
    step();
    insert = 1'b0;
    req_cycles = 0; seen_seed = 0;
    for (int i = 0; i < 20; i++) begin
      if (!entropy_req) break;
      req_cycles++;
      step();
      if (seed_en) seen_seed = 1;
    end
    check("t3_req_cycles", 64'(req_cycles), 64'(5));
    check("t3_err",        64'(reseed_err), 64'(1));
    check("t3_no_seed",    64'(seen_seed),  64'(0));
    check("t3_run",        64'(dummy_en),   64'(1));
    check("t3_seed_kept",  64'(seed),       64'(32'h1234_5678));
    for (int i = 0; i < 3; i++) step();
    check("t3_err_sticky", 64'(reseed_err), 64'(1));
    interval = '0; timeout = '0;

    // Disable during a request: held until ack, then disabled without seeding.
    reseed_now = 1'b1;
    step();
    reseed_now = 1'b0;
    check("t4_req", 64'(entropy_req), 64'(1));
    ctrl_en = 1'b0;
    step();
    check("t4_req_held1", 64'(entropy_req), 64'(1));
    step();
    check("t4_req_held2", 64'(entropy_req), 64'(1));
    entropy_ack = 1'b1; entropy_data = 32'hCAFE_F00D;
    step();
    entropy_ack = 1'b0;
    check("t4_req_drop", 64'(entropy_req), 64'(0));
    check("t4_no_seed",  64'(seed_en),     64'(0));
    check("t4_busy",     64'(busy),        64'(0));
    step(); step();
    check("t4_en_off", 64'(dummy_en), 64'(0));
    ctrl_en = 1'b1;
    step();
    entropy_ack = 1'b1; entropy_data = 32'h0BAD_CAFE;
    step();
    entropy_ack = 1'b0;
    check("t4_seed", 64'(seed), 64'(32'h0BAD_CAFE));
    step();

    // Software reseed; a second pulse inside the request is absorbed.
    reseed_now = 1'b1;
    step();
    reseed_now = 1'b0;
    check("t5_req_next", 64'(entropy_req), 64'(1));
    reseed_now = 1'b1;
    step();
    reseed_now = 1'b0;
    entropy_ack = 1'b1; entropy_data = 32'h5555_AAAA;
    step();
    entropy_ack = 1'b0;
    check("t5_seed_en", 64'(seed_en), 64'(1));
    req_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (entropy_req) req_cycles++;
    end
    check("t5_single_reseed", 64'(req_cycles), 64'(0));

    // Saturation and clear-with-event.
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    check("t6_cleared", 64'(dummy_count), 64'(0));
    insert = 1'b1; ready = 1'b1;
    repeat (65535) step();
    check("t6_full", 64'(dummy_count), 64'(16'hFFFF));
    step();
    check("t6_saturated", 64'(dummy_count), 64'(16'hFFFF));
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    check("t6_clear_event", 64'(dummy_count), 64'(1));
    insert = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 499) == 0);
      ctrl_en     = ($urandom_range(0, 19) != 0);
      ctrl_mask   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) interval = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0) timeout  = 8'($urandom_range(0, 6));
      reseed_now  = ($urandom_range(0, 29) == 0);
      entropy_ack = (m_mode == M_REQ) && ($urandom_range(0, 3) == 0);
      entropy_data = 32'($urandom);
      insert      = ($urandom_range(0, 1) == 1);
      ready       = ($urandom_range(0, 3) != 0);
      clear_count = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
